// File: rtl/ds_pkg.sv
// ds_pkg: shared control codes, framing state encoding and NULL hunt pattern for the DS receiver.
package ds_pkg;
  localparam logic [1:0] CODE_FCC  = 2'b00;
  localparam logic [1:0] CODE_EOP1 = 2'b01;
  localparam logic [1:0] CODE_EOP2 = 2'b10;
  localparam logic [1:0] CODE_ESC  = 2'b11;
  localparam logic [2:0] HUNT = 3'd0;
  localparam logic [2:0] PAR  = 3'd1;
  localparam logic [2:0] FLAG = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] CTRL = 3'd4;
  localparam logic [6:0] NULL_PAT = 7'b1110100;
endpackage

// File: rtl/ds_bit_recover.sv
// ds_bit_recover: synchronizes the DS pair, emits one bit strobe per d/s transition and times out idle links.
module ds_bit_recover #(
  parameter int DISC_CYCLES = 85
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  input  logic s_in,
  input  logic link_up,
  output logic bit_stb,
  output logic bit_val,
  output logic timeout
);
  localparam int CW = $clog2(DISC_CYCLES + 1);
  logic [2:0] d_q, s_q;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d_q <= '0;
      s_q <= '0;
      bit_stb <= 1'b0;
      bit_val <= 1'b0;
      cnt <= '0;
    end else begin
      d_q <= {d_q[1:0], d_in};
      s_q <= {s_q[1:0], s_in};
      bit_stb <= (d_q[1] ^ s_q[1]) != (d_q[2] ^ s_q[2]);
      bit_val <= d_q[1];
      cnt <= (bit_stb || !link_up) ? '0 : cnt + 1'b1;
    end
  // fires one clock early so the registered disc_err lands exactly DISC_CYCLES after the strobe
  assign timeout = link_up && !bit_stb && cnt == CW'(DISC_CYCLES - 2);
endmodule

// File: rtl/ds_rx_decoder.sv
// ds_rx_decoder: DS-SE link receiver framing recovered bits into data/control characters with
// parity, NULL, ESC and disconnect checking.
module ds_rx_decoder
  import ds_pkg::*;
#(
  parameter int DISC_CYCLES = 85
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       d_in,
  input  logic       s_in,
  output logic       char_valid,
  output logic       char_is_ctrl,
  output logic [7:0] char_data,
  output logic       null_det,
  output logic       fcc_det,
  output logic       link_up,
  output logic       par_err,
  output logic       esc_err,
  output logic       disc_err
);
  logic bit_stb, bit_val, timeout;
  logic [2:0] state, state_n;
  logic [6:0] win, win_n;
  logic [3:0] cnt;
  logic [7:0] sh, sh_n;
  logic [1:0] code;
  logic p, prev_par, esc_pend;
  logic done, is_ctrl, is_fcc, hunt_hit, p_bad, e_bad, fail;
  ds_bit_recover #(.DISC_CYCLES(DISC_CYCLES)) u_rec (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .s_in(s_in), .link_up(link_up),
    .bit_stb(bit_stb), .bit_val(bit_val), .timeout(timeout)
  );
  always_comb begin
    win_n = {win[5:0], bit_val};
    sh_n = {bit_val, sh[7:1]};
    code = {sh_n[6], sh_n[7]};
    is_ctrl = state == CTRL;
    is_fcc = is_ctrl && code == CODE_FCC;
    done = bit_stb && cnt == 4'd1 && (state == DATA || state == CTRL);
    hunt_hit = bit_stb && state == HUNT && win_n == NULL_PAT;
    p_bad = bit_stb && state == FLAG && !(p ^ prev_par ^ bit_val);
    e_bad = done && esc_pend && !is_fcc;
    fail = timeout || p_bad || e_bad;
    state_n = fail ? HUNT :
              !bit_stb ? state :
              state == HUNT ? (hunt_hit ? PAR : HUNT) :
              state == PAR ? FLAG :
              state == FLAG ? (bit_val ? CTRL : DATA) :
              done ? PAR : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= HUNT;
      win <= '0;
      cnt <= '0;
      sh <= '0;
      p <= 1'b0;
      prev_par <= 1'b0;
      esc_pend <= 1'b0;
      {char_valid, char_is_ctrl, char_data, null_det, fcc_det, link_up, par_err, esc_err, disc_err} <= '0;
    end else begin
      state <= state_n;
      char_valid <= done && !esc_pend && (!is_ctrl || ^code);
      null_det <= hunt_hit || (done && esc_pend && is_fcc);
      fcc_det <= done && !esc_pend && is_fcc;
      par_err <= p_bad;
      esc_err <= e_bad;
      disc_err <= timeout;
      link_up <= !fail && (link_up || hunt_hit);
      esc_pend <= !fail && (done ? (!esc_pend && is_ctrl && code == CODE_ESC) : esc_pend);
      if (done) begin
        char_is_ctrl <= is_ctrl;
        char_data <= is_ctrl ? {6'b0, code} : sh_n;
        prev_par <= is_ctrl ? ^code : ^sh_n;
      end else if (hunt_hit) prev_par <= 1'b0;
      if (fail) win <= '0;
      else if (bit_stb && state == HUNT) win <= win_n;
      if (bit_stb && state == PAR) p <= bit_val;
      if (bit_stb && state == FLAG) cnt <= bit_val ? 4'd2 : 4'd8;
      if (bit_stb && (state == DATA || state == CTRL)) begin
        sh <= sh_n;
        cnt <= cnt - 4'd1;
      end
    end
endmodule

// File: tb/tb_ds_rx_decoder.sv
// tb_ds_rx_decoder: directed DS link stimulus with hand-derived expected strobes and timing.
module tb_ds_rx_decoder;
  logic clk = 1'b0, rst_n = 1'b0, d_in = 1'b0, s_in = 1'b0;
  logic char_valid, char_is_ctrl, null_det, fcc_det, link_up, par_err, esc_err, disc_err;
  logic [7:0] char_data;
  int cyc = 0, last_drv = 0, errors = 0, checks = 0, n_cv = 0, n_disc = 0, n_err = 0;
  logic tp = 1'b0;

  ds_rx_decoder #(.DISC_CYCLES(85)) dut (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .s_in(s_in),
    .char_valid(char_valid), .char_is_ctrl(char_is_ctrl), .char_data(char_data),
    .null_det(null_det), .fcc_det(fcc_det), .link_up(link_up),
    .par_err(par_err), .esc_err(esc_err), .disc_err(disc_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (char_valid) n_cv++;
    if (disc_err) n_disc++;
    if (par_err || esc_err || disc_err) n_err++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  // DS encoding: strobe toggles only when data repeats; one bit every 4 clocks
  task automatic send_bit(input logic b);
    @(negedge clk);
    if (b == d_in) s_in = ~s_in;
    d_in = b;
    last_drv = cyc;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_data(input logic [7:0] v);
    send_bit(~tp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    tp = ^v;
  endtask

  task automatic send_ctrl(input logic [1:0] c);
    send_bit(tp);
    send_bit(1'b1);
    send_bit(c[1]);
    send_bit(c[0]);
    tp = ^c;
  endtask

  task automatic send_null;
    send_ctrl(2'b11);
    send_ctrl(2'b00);
  endtask

  task automatic test_reset;
    repeat (4) @(negedge clk);
    checks++;
    if ({char_valid, char_is_ctrl, char_data, null_det, fcc_det, link_up, par_err, esc_err, disc_err} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h exp 0000",
               {char_valid, char_is_ctrl, char_data, null_det, fcc_det, link_up, par_err, esc_err, disc_err});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sync;
    send_null;
    checks++;
    if ({null_det, link_up} !== 2'b00) begin
      errors++; $display("FAIL sync_early: null/link got %b exp 00", {null_det, link_up});
    end
    @(negedge clk);
    checks++;
    if ({null_det, link_up} !== 2'b11) begin
      errors++; $display("FAIL sync_first_null: null/link got %b exp 11", {null_det, link_up});
    end
    for (int k = 0; k < 2; k++) begin
      send_null;
      @(negedge clk);
      checks++;
      if ({null_det, link_up} !== 2'b11) begin
        errors++; $display("FAIL sync_null_%0d: null/link got %b exp 11", k, {null_det, link_up});
      end
    end
    checks++;
    if (n_err !== 0) begin
      errors++; $display("FAIL sync_no_errors: got %0d exp 0", n_err);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] vals [2];
    vals = '{8'hA5, 8'h3C};
    for (int i = 0; i < 2; i++) begin
      send_data(vals[i]);
      checks++;
      if (char_valid !== 1'b0) begin
        errors++; $display("FAIL data_early_%0d: char_valid got %b exp 0", i, char_valid);
      end
      @(negedge clk);
      checks++;
      if ({char_valid, char_is_ctrl, char_data} !== {2'b10, vals[i]}) begin
        errors++; $display("FAIL data_%0d: valid/ctrl/data got %b/%b/%h exp 1/0/%h",
                           i, char_valid, char_is_ctrl, char_data, vals[i]);
      end
    end
  endtask

  task automatic test_ctrl;
    logic [1:0] codes [2];
    codes = '{2'b01, 2'b10};
    for (int i = 0; i < 2; i++) begin
      send_ctrl(codes[i]);
      @(negedge clk);
      checks++;
      if ({char_valid, char_is_ctrl, char_data} !== {2'b11, 6'b0, codes[i]}) begin
        errors++; $display("FAIL ctrl_%0d: valid/ctrl/data got %b/%b/%h exp 1/1/%h",
                           i, char_valid, char_is_ctrl, char_data, {6'b0, codes[i]});
      end
    end
    send_ctrl(2'b00);
    @(negedge clk);
    checks++;
    if ({fcc_det, null_det, char_valid} !== 3'b100) begin
      errors++; $display("FAIL ctrl_fcc: fcc/null/valid got %b exp 100", {fcc_det, null_det, char_valid});
    end
  endtask

  task automatic test_parity;
    int cv0;
    cv0 = n_cv;
    send_bit(tp);
    send_bit(1'b0);
    @(negedge clk);
    checks++;
    if ({par_err, link_up} !== 2'b10) begin
      errors++; $display("FAIL parity_err: par_err/link got %b exp 10", {par_err, link_up});
    end
    for (int i = 0; i < 8; i++) send_bit(i[0] ? 1'b0 : 1'b1);
    tp = 1'b0;
    @(negedge clk);
    checks++;
    if (n_cv !== cv0) begin
      errors++; $display("FAIL parity_suppress: char_valid count got %0d exp %0d", n_cv, cv0);
    end
    send_null;
    @(negedge clk);
    checks++;
    if ({null_det, link_up} !== 2'b11) begin
      errors++; $display("FAIL parity_relink: null/link got %b exp 11", {null_det, link_up});
    end
  endtask

  task automatic test_esc_disc;
    int d0;
    send_ctrl(2'b11);
    send_data(8'h11);
    @(negedge clk);
    checks++;
    if ({esc_err, link_up, char_valid} !== 3'b100) begin
      errors++; $display("FAIL esc_err: esc/link/valid got %b exp 100", {esc_err, link_up, char_valid});
    end
    send_null;
    d0 = n_disc;
    while (cyc < last_drv + 87) @(negedge clk);
    checks++;
    if ({disc_err, link_up} !== 2'b01) begin
      errors++; $display("FAIL disc_early: disc/link got %b exp 01", {disc_err, link_up});
    end
    @(negedge clk);
    checks++;
    if ({disc_err, link_up} !== 2'b10) begin
      errors++; $display("FAIL disc_at_85: disc/link got %b exp 10", {disc_err, link_up});
    end
    repeat (200) @(negedge clk);
    checks++;
    if (n_disc !== d0 + 1) begin
      errors++; $display("FAIL disc_unlinked: disc count got %0d exp %0d", n_disc, d0 + 1);
    end
  endtask

  task automatic test_reset_mid;
    int cv0;
    send_null;
    send_bit(~tp);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({char_valid, char_is_ctrl, char_data, null_det, fcc_det, link_up, par_err, esc_err, disc_err} !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid: got %h exp 0000",
               {char_valid, char_is_ctrl, char_data, null_det, fcc_det, link_up, par_err, esc_err, disc_err});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cv0 = n_cv;
    for (int i = 0; i < 10; i++) send_bit(1'b0);
    checks++;
    if ({n_cv != cv0, link_up} !== 2'b00) begin
      errors++; $display("FAIL reset_spurious: extra valids %0d link %b exp 0 0", n_cv - cv0, link_up);
    end
    send_null;
    send_data(8'hC3);
    @(negedge clk);
    checks++;
    if ({char_valid, char_is_ctrl, char_data, link_up} !== {2'b10, 8'hC3, 1'b1}) begin
      errors++; $display("FAIL reset_recover: valid/ctrl/data/link got %b/%b/%h/%b exp 1/0/c3/1",
                         char_valid, char_is_ctrl, char_data, link_up);
    end
  endtask

  initial begin
    test_reset;
    test_sync;
    test_back_to_back;
    test_ctrl;
    test_parity;
    test_esc_disc;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ds_rx_decoder.md
# ds_rx_decoder

Receive half of the IEEE 1355 DS-SE link inside `node`. It samples the data/strobe pair (`d_inA`/`s_inA`) on the system clock and recovers one bit per DS transition. It frames the bits into data and control characters, checks odd parity, and detects nulls and disconnects. Decoded characters go to the node's character FIFO/LED logic as single-cycle strobes.

## Interface
- `DISC_CYCLES`, default 85: clocks without any d/s edge, while linked, before a disconnect is declared (850 ns at 100 MHz).
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `d_in`  in  1  DS data line, asynchronous to `clk`.
- `s_in`  in  1  DS strobe line, asynchronous to `clk`.
- `char_valid`  out  1  one-cycle strobe: `char_is_ctrl` and `char_data` are valid.
- `char_is_ctrl`  out  1  1 = control char (EOP_1/EOP_2); 0 = data char.
- `char_data`  out  8  data byte; for control chars, the code is in [1:0] and [7:2] = 0.
- `null_det`  out  1  one-cycle strobe per received NULL (ESC+FCC).
- `fcc_det`  out  1  one-cycle strobe per standalone FCC.
- `link_up`  out  1  level; set by the first NULL, cleared by any error.
- `par_err`  out  1  one-cycle strobe on a parity failure.
- `esc_err`  out  1  one-cycle strobe when ESC is followed by anything but FCC.
- `disc_err`  out  1  one-cycle strobe on disconnect timeout.
- Reset value of every output is 0.

## Operation
- **Bit recovery**
  - `d_in` and `s_in` pass through a 2-FF synchronizer; a third register stage is used for edge detect.
  - A bit strobe fires when (d XOR s) changes. The bit value is the synchronized d at that cycle.
- **Character format** (transmission order)
  - P, F, then 8 data bits LSB first (F=0), or 2 code bits (F=1).
  - Control code = {first code bit, second}: FCC=00, EOP_1=01, EOP_2=10, ESC=11.
  - Odd parity: P XOR (data/code bits of the previous char) XOR F = 1.
- **States**
  - HUNT: shift bits into a 7-bit window. On window (arrival order) 1,1,1,0,1,0,0 (ESC tail + FCC with P=0), go to PAR, assert `null_det` and set `link_up`. The previous-char parity contribution is then 0 (FCC bits).
  - PAR: capture P → FLAG.
  - FLAG: capture F; check parity using stored previous parity → DATA (F=0, count 8) or CTRL (F=1, count 2).
  - DATA/CTRL: shift bits. After the last bit, emit the character and return to PAR.
- **Character handling**
  - FCC not preceded by ESC → `fcc_det`.
  - ESC is held pending. A following FCC gives `null_det`; anything else gives `esc_err`.
  - ESC is never emitted on `char_valid`.
- **Errors**
  - `par_err`, `esc_err` and `disc_err` each clear `link_up`, drop any pending char/ESC, and force HUNT.
  - A parity error detected at FLAG suppresses the character in flight.
- **Disconnect timer**
  - Runs only while `link_up` = 1 and reloads on every edge.
  - At terminal count: `disc_err` and HUNT. No timeout is raised in HUNT.
- Reset mid-character: everything returns to HUNT immediately, with no partial output.

## Timing
- Input to bit strobe: 3 clocks (2 sync + edge register).
- `char_valid`, `null_det`, `fcc_det` and `par_err` assert on the cycle after the final bit's strobe, for exactly 1 clock.
- `link_up` rises in the same cycle as the first `null_det`.
- Edges must be at least 2 clocks apart; closer edges are undefined.
- Disconnect: `disc_err` asserts exactly `DISC_CYCLES` clocks after the last edge strobe.
- Simultaneous error and character completion: the error wins and no char is emitted.

## Structure
- `ds_pkg` holds:
  - control code localparams `CODE_FCC`, `CODE_EOP1`, `CODE_EOP2`, `CODE_ESC`;
  - the state encoding HUNT/PAR/FLAG/DATA/CTRL;
  - the null hunt pattern 7'b1110100.
- Sub-module `ds_bit_recover` contains the synchronizer, edge detect, bit strobe and disconnect counter. It outputs `bit_stb`, `bit_val` and `timeout`.
- The top module holds the framing FSM, parity tracking and output registers.

## Test plan
- Reset, then stream NULLs at 1 bit/4 clk → first `null_det` and `link_up` rise after the 7-bit pattern; one `null_det` per subsequent NULL; no errors.
- After sync, data 8'hA5 then 8'h3C → `char_valid` twice, `char_is_ctrl`=0, `char_data`=A5 then 3C, each 1 clk after the last bit.
- After sync, EOP_1 then EOP_2 → `char_valid` with `char_is_ctrl`=1, `char_data`=8'h01 then 8'h02.
- Flip the P bit of a data char → `par_err` 1 clk after the flag bit; no `char_valid`; `link_up`=0; relinks on the next NULL.
- After sync, send ESC then data → `esc_err`; stop all edges → `disc_err` exactly 85 clk after the last edge, only if linked.
- Assert `rst_n`=0 mid-byte → all outputs 0 immediately; after release, HUNT and no spurious `char_valid`.
